vga_mode_ctrl: RTL and testbench
================================

Name: vga_mode_ctrl

Overview:
Frame-synchronous mode sequencer for the 160x160 picture pipeline on the 800x480 raster. It turns debounced key pulses into the one-hot mode word consumed by the picture/Sobel datapath. It applies mode changes only at frame end, and enforces a Sobel capture pass before edge display. It also owns the scroll-mode picture position and offset counters.

Parameters:
HOR_SCREEN, 800, active pixels per line
VERT_SCREEN, 480, active lines per frame
HOR_PIC, 160, picture width
START_X, 500, picture origin x after reset or mode exit
START_Y, 200, picture origin y
CAP_TIMEOUT, 3, frames allowed for a capture pass before abort

Ports:
clk  in  1  pixel clock
rstn  in  1  reset, asynchronous, active-low
key_req  in  4  one-cycle key pulses: [0]=color, [1]=gray, [2]=edge, [3]=scroll
pix_x  in  10  current pixel x
pix_y  in  10  current pixel y
cap_done  in  1  one-cycle pulse when the edge RAM write address wraps (last word written)
mode_out  out  4  one-hot mode to datapath: 0000 idle, 0001 color, 0010 gray, 0100 edge, 1000 scroll
pic_start_x  out  10  picture origin x
pic_start_y  out  10  picture origin y
scroll_offset  out  10  left-crop offset in scroll mode
cap_busy  out  1  high while a capture pass is running
cap_err  out  1  sticky; set on capture timeout
frame_end  out  1  registered pulse, one cycle after pix_x==HOR_SCREEN-1 && pix_y==VERT_SCREEN-1

Behaviour:
- Reset values: mode_out=0000, pic_start_x=START_X, pic_start_y=START_Y, scroll_offset=0, cap_busy=0, cap_err=0, frame_end=0, FSM=IDLE, pending=none, edge_valid=0.
- Key intake: a key_req value with exactly one bit set overwrites the pending request; the last one wins. Zero or multi-bit values are ignored. Pending is cleared when it is consumed.
- FE = combinational frame-end condition. All FSM transitions and all mode_out updates occur only on the clk edge where FE is true. A request arriving on the FE cycle itself is taken at that edge.
- Toggle rule: a pending request equal to the current mode makes the next state IDLE.
- FSM states and mode_out:
  - IDLE: mode_out 0000.
  - COLOR: mode_out 0001.
  - GRAY: mode_out 0010.
  - CAPTURE: mode_out 0010, cap_busy=1.
  - EDGE: mode_out 0100.
  - SCROLL: mode_out 1000.
- Transitions at FE with pending request R:
  - R=color -> COLOR; R=gray -> GRAY; R=scroll -> SCROLL.
  - R=edge -> EDGE if edge_valid=1, else -> CAPTURE.
- CAPTURE:
  - On cap_done (any cycle): set edge_valid=1 and clear cap_busy; the FSM moves to EDGE at the next FE.
  - Frame counter increments at each FE. If it reaches CAP_TIMEOUT without cap_done: set cap_err, go to IDLE.
  - A new pending request at FE aborts capture and is applied normally; edge_valid stays 0.
- edge_valid is set once by cap_done and cleared only by reset. cap_done outside CAPTURE also sets edge_valid, because color, gray and scroll modes also write the RAM.
- cap_err clears on reset or on entry to CAPTURE.
- SCROLL, evaluated at each FE while in SCROLL:
  - If pic_start_x >= 2: pic_start_x decrements by 1.
  - Else if scroll_offset == HOR_PIC-1: scroll_offset=0, pic_start_x=START_X.
  - Else: scroll_offset increments by 1.
- Any transition out of SCROLL restores pic_start_x=START_X and scroll_offset=0 at that same edge. pic_start_y is constant at START_Y in this revision.
- Width: comparisons are 10-bit unsigned; pic_start_x never underflows below 1.
- Reset mid-frame or mid-capture: immediate return to reset values; no pending request survives.

Decomposition:
- Shared package vga_pkg:
  - Mode one-hot constants MODE_IDLE, MODE_COLOR, MODE_GRAY, MODE_EDGE, MODE_SCROLL.
  - Screen and picture size constants.
  - FSM state enum.
- One sub-module, vga_scroll_ctr: holds pic_start_x/scroll_offset. Inputs are step (FE & in SCROLL) and clear (leaving SCROLL).
- The FSM, key latch and capture timer stay in the top.

Test Plan:
- Reset, then color pulse at (10,5) -> mode_out stays 0000 until frame end (799,479), becomes 0001 on the next cycle; frame_end pulses once.
- Gray then color pulses in the same frame -> only 0001 is applied at frame end; a two-bit key_req 0011 leaves mode_out unchanged.
- Edge pulse with edge_valid=0 -> mode_out 0010 and cap_busy=1. Then cap_done mid-frame -> cap_busy=0, and mode_out=0100 at the following frame end. A second edge request later goes straight to 0100.
- Edge pulse with cap_done never asserted -> after 3 frame ends cap_err=1 and mode_out=0000.
- Scroll for 499 frames -> pic_start_x 500 falls to 1 with offset 0. The next 159 frames step offset 1..159, then the following frame gives offset=0, x=500. A color press then restores x=500, offset=0.
- Pressing scroll while in SCROLL -> IDLE at frame end with x=500, offset=0. rstn low mid-frame -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the 160x160 picture pipeline on the
// 800x480 raster.
//   - Screen/picture geometry and the capture timeout.
//   - One-hot mode words driven to the picture/Sobel datapath. Key request
//     bits use the same layout, so a one-hot key value is directly a mode word.
//   - Mode sequencer FSM state enum and its state-to-mode decode.
package vga_pkg;

  localparam logic [9:0] HOR_SCREEN  = 10'd800;
  localparam logic [9:0] VERT_SCREEN = 10'd480;
  localparam logic [9:0] HOR_PIC     = 10'd160;
  localparam logic [9:0] START_X     = 10'd500;
  localparam logic [9:0] START_Y     = 10'd200;
  localparam logic [1:0] CAP_TIMEOUT = 2'd3;

  localparam logic [3:0] MODE_IDLE   = 4'b0000;
  localparam logic [3:0] MODE_COLOR  = 4'b0001;
  localparam logic [3:0] MODE_GRAY   = 4'b0010;
  localparam logic [3:0] MODE_EDGE   = 4'b0100;
  localparam logic [3:0] MODE_SCROLL = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLOR,
    ST_GRAY,
    ST_CAPTURE,
    ST_EDGE,
    ST_SCROLL
  } state_e;

  // CAPTURE shows the gray picture while the edge RAM is being filled.
  function automatic logic [3:0] state_mode(input state_e s);
    logic [3:0] m;
    m = MODE_IDLE;
    case (s)
      ST_COLOR:   m = MODE_COLOR;
      ST_GRAY:    m = MODE_GRAY;
      ST_CAPTURE: m = MODE_GRAY;
      ST_EDGE:    m = MODE_EDGE;
      ST_SCROLL:  m = MODE_SCROLL;
      default:    m = MODE_IDLE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/vga_scroll_ctr.sv
// vga_scroll_ctr: scroll-mode picture position.
//   clk, rstn      pixel clock, async active-low reset
//   step           one scroll step (frame end while staying in scroll mode)
//   clear          leaving scroll mode: restore origin and offset
//   pic_start_x    picture origin x (walks left from START_X down to 1)
//   scroll_offset  left-crop offset once the picture has reached x=1
module vga_scroll_ctr
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       step,
  input  logic       clear,
  output logic [9:0] pic_start_x,
  output logic [9:0] scroll_offset
);

  logic [9:0] x_q, x_d;
  logic [9:0] off_q, off_d;

  // The picture first slides left to x=1, then is cropped from the left one
  // column per frame; after the last column it restarts at START_X.
  always_comb begin
    x_d   = x_q;
    off_d = off_q;
    if (clear) begin
      x_d   = START_X;
      off_d = '0;
    end else if (step) begin
      if (x_q >= 10'd2) begin
        x_d = x_q - 10'd1;
      end else if (off_q == HOR_PIC - 10'd1) begin
        x_d   = START_X;
        off_d = '0;
      end else begin
        off_d = off_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_q   <= START_X;
      off_q <= '0;
    end else begin
      x_q   <= x_d;
      off_q <= off_d;
    end
  end

  assign pic_start_x   = x_q;
  assign scroll_offset = off_q;

endmodule

// File: rtl/vga_mode_ctrl.sv
// vga_mode_ctrl: frame-synchronous mode sequencer.
//   clk, rstn      pixel clock, async active-low reset
//   key_req[3:0]   one-cycle key pulses: [0] color, [1] gray, [2] edge, [3] scroll
//   pix_x, pix_y   current raster position
//   cap_done       edge RAM write address wrapped (last word written)
//   mode_out       one-hot mode word to the datapath
//   pic_start_x/y  picture origin; scroll_offset  left crop in scroll mode
//   cap_busy       capture pass in progress
//   cap_err        sticky capture timeout flag
//   frame_end      registered pulse one cycle after the last active pixel
// Key presses are latched (last one wins) and applied only at frame end.
// Edge display requires a completed capture pass (edge_valid) first.
module vga_mode_ctrl
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] key_req,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       cap_done,
  output logic [3:0] mode_out,
  output logic [9:0] pic_start_x,
  output logic [9:0] pic_start_y,
  output logic [9:0] scroll_offset,
  output logic       cap_busy,
  output logic       cap_err,
  output logic       frame_end
);

  state_e     state_q, state_d;
  logic [3:0] pend_q, pend_d;
  logic [1:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       ev_q, ev_d;
  logic       fe_q;

  logic       fe;
  logic       key_ok;
  logic [3:0] req;
  logic       scroll_step, scroll_clear;

  assign fe     = (pix_x == HOR_SCREEN - 10'd1) && (pix_y == VERT_SCREEN - 10'd1);
  assign key_ok = (key_req != 4'd0) && ((key_req & (key_req - 4'd1)) == 4'd0);
  // A valid key on the frame-end cycle itself takes priority over the latch.
  assign req    = key_ok ? key_req : pend_q;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ev_d    = ev_q | cap_done;
    if (fe) begin
      pend_d = '0;
      if (req != MODE_IDLE) begin
        // Pressing the key of the mode currently on the output turns it off.
        if (req == mode_out) begin
          state_d = ST_IDLE;
        end else begin
          case (req)
            MODE_COLOR:  state_d = ST_COLOR;
            MODE_GRAY:   state_d = ST_GRAY;
            MODE_SCROLL: state_d = ST_SCROLL;
            default: begin
              if (ev_q) begin
                state_d = ST_EDGE;
              end else begin
                state_d = ST_CAPTURE;
                cnt_d   = '0;
                err_d   = 1'b0;
              end
            end
          endcase
        end
      end else if (state_q == ST_CAPTURE) begin
        if (ev_q) begin
          state_d = ST_EDGE;
        end else begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_d == CAP_TIMEOUT) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
      end
    end else if (key_ok) begin
      pend_d = key_req;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ev_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ev_q    <= ev_d;
      fe_q    <= fe;
    end
  end

  assign scroll_step  = fe && (state_q == ST_SCROLL) && (state_d == ST_SCROLL);
  assign scroll_clear = fe && (state_q == ST_SCROLL) && (state_d != ST_SCROLL);

  vga_scroll_ctr u_scroll (
    .clk           (clk),
    .rstn          (rstn),
    .step          (scroll_step),
    .clear         (scroll_clear),
    .pic_start_x   (pic_start_x),
    .scroll_offset (scroll_offset)
  );

  assign mode_out    = state_mode(state_q);
  assign pic_start_y = START_Y;
  // Busy ends as soon as the RAM has been fully written; the switch to edge
  // display still waits for the next frame end.
  assign cap_busy    = (state_q == ST_CAPTURE) && !ev_q;
  assign cap_err     = err_q;
  assign frame_end   = fe_q;

endmodule

// File: tb/tb_vga_mode_ctrl.sv
module tb_vga_mode_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] key_req;
  logic [9:0] pix_x, pix_y;
  logic       cap_done;
  logic [3:0] mode_out;
  logic [9:0] pic_start_x, pic_start_y, scroll_offset;
  logic       cap_busy, cap_err, frame_end;

  int n_checks = 0;
  int n_fail   = 0;

  vga_mode_ctrl dut (
    .clk           (clk),
    .rstn          (rstn),
    .key_req       (key_req),
    .pix_x         (pix_x),
    .pix_y         (pix_y),
    .cap_done      (cap_done),
    .mode_out      (mode_out),
    .pic_start_x   (pic_start_x),
    .pic_start_y   (pic_start_y),
    .scroll_offset (scroll_offset),
    .cap_busy      (cap_busy),
    .cap_err       (cap_err),
    .frame_end     (frame_end)
  );

  always #5 clk = ~clk;

  // Behavioural model: visible mode word, capture flag, pending key, flags,
  // capture frame count and number of scroll frames since entering scroll.
  logic [3:0] m_mode, m_pend;
  bit         m_cap, m_ev, m_err, m_fe;
  int         m_cnt, m_k;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 4'b0000; m_pend = 4'b0000;
    m_cap = 0; m_ev = 0; m_err = 0; m_fe = 0;
    m_cnt = 0; m_k = 0;
  endtask

  task automatic model_step(input logic [3:0] kr, input bit fe, input bit cd);
    bit kv, old_ev, ncap;
    logic [3:0] req, nm;
    kv = ($countones(kr) == 1);
    req = kv ? kr : m_pend;
    old_ev = m_ev;
    nm = m_mode;
    ncap = m_cap;
    if (cd) m_ev = 1;
    m_fe = fe;
    if (fe) begin
      m_pend = 4'b0000;
      if (req != 4'b0000) begin
        if (req == m_mode) begin nm = 4'b0000; ncap = 0; end
        else if (req == 4'b0100) begin
          if (old_ev) begin nm = 4'b0100; ncap = 0; end
          else begin nm = 4'b0010; ncap = 1; m_cnt = 0; m_err = 0; end
        end else begin nm = req; ncap = 0; end
      end else if (m_cap) begin
        if (old_ev) begin nm = 4'b0100; ncap = 0; end
        else begin
          m_cnt++;
          if (m_cnt == 3) begin nm = 4'b0000; ncap = 0; m_err = 1; end
        end
      end
      if (m_mode == 4'b1000 && nm == 4'b1000) m_k++;
      else m_k = 0;
      m_mode = nm;
      m_cap = ncap;
    end else if (kv) begin
      m_pend = kr;
    end
  endtask

  // Scroll position as a closed-form function of frames spent scrolling:
  // 499 frames walking x from 500 to 1, then 160 crop offsets, period 659.
  task automatic check_model();
    int r, ex, eo;
    r = m_k % 659;
    if (r <= 499) begin ex = 500 - r; eo = 0; end
    else begin ex = 1; eo = r - 499; end
    chk("mode_out",      mode_out,      m_mode);
    chk("pic_start_x",   pic_start_x,   ex);
    chk("pic_start_y",   pic_start_y,   200);
    chk("scroll_offset", scroll_offset, eo);
    chk("cap_busy",      cap_busy,      (m_cap && !m_ev) ? 1 : 0);
    chk("cap_err",       cap_err,       m_err ? 1 : 0);
    chk("frame_end",     frame_end,     m_fe ? 1 : 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_mode"}, mode_out, 0);
    chk({tag, "_x"},    pic_start_x, 500);
    chk({tag, "_y"},    pic_start_y, 200);
    chk({tag, "_off"},  scroll_offset, 0);
    chk({tag, "_busy"}, cap_busy, 0);
    chk({tag, "_err"},  cap_err, 0);
    chk({tag, "_fe"},   frame_end, 0);
  endtask

  // Starts and ends at a negedge: drive, clock, update model, compare.
  task automatic cyc(input logic [3:0] kr, input bit fe, input bit cd);
    key_req = kr;
    cap_done = cd;
    if (fe) begin
      pix_x = 10'd799; pix_y = 10'd479;
    end else if ($urandom_range(0, 3) == 0) begin
      pix_x = 10'd799; pix_y = 10'($urandom_range(0, 478));
    end else begin
      pix_x = 10'($urandom_range(0, 798)); pix_y = 10'($urandom_range(0, 479));
    end
    @(posedge clk);
    model_step(kr, fe, cd);
    @(negedge clk);
    check_model();
  endtask

  task automatic idle_inputs();
    key_req = 4'b0000; cap_done = 1'b0; pix_x = 10'd10; pix_y = 10'd5;
  endtask

  task automatic do_reset();
    cyc(4'b1000, 0, 0);   // leaves a pending key that reset must discard
    idle_inputs();
    #2 rstn = 1'b0;
    #1 check_reset_vals("async_rst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(4'b0000, 0, 0);
      cyc(4'b0000, 1, 0);
    end
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rstn = 1'b1;

    // Last key wins; nothing changes before frame end.
    cyc(4'b0010, 0, 0);
    cyc(4'b0001, 0, 0);
    cyc(4'b0000, 0, 0);
    chk("before_fe", mode_out, 4'b0000);
    cyc(4'b0000, 1, 0);
    chk("color_applied", mode_out, 4'b0001);
    chk("fe_pulse", frame_end, 1);
    cyc(4'b0000, 0, 0);
    chk("fe_single", frame_end, 0);
    cyc(4'b0011, 0, 0);
    cyc(4'b0000, 1, 0);
    chk("multibit_ignored", mode_out, 4'b0001);
    cyc(4'b0001, 1, 0);
    chk("toggle_off", mode_out, 4'b0000);

    // Capture then edge display.
    cyc(4'b0100, 0, 0);
    cyc(4'b0000, 1, 0);
    chk("capture_mode", mode_out, 4'b0010);
    chk("capture_busy", cap_busy, 1);
    cyc(4'b0000, 0, 0);
    cyc(4'b0000, 0, 1);
    cyc(4'b0000, 0, 0);
    chk("busy_cleared", cap_busy, 0);
    chk("still_gray", mode_out, 4'b0010);
    cyc(4'b0000, 1, 0);
    chk("edge_after_cap", mode_out, 4'b0100);
    cyc(4'b0001, 1, 0);
    cyc(4'b0100, 1, 0);
    chk("edge_direct", mode_out, 4'b0100);
    chk("edge_direct_busy", cap_busy, 0);

    // Capture timeout.
    do_reset();
    cyc(4'b0100, 1, 0);
    chk("to_capture", mode_out, 4'b0010);
    frames(2);
    chk("to_not_yet", cap_err, 0);
    frames(1);
    chk("to_err", cap_err, 1);
    chk("to_idle", mode_out, 4'b0000);

    // Scroll sweep.
    cyc(4'b1000, 1, 0);
    chk("scroll_mode", mode_out, 4'b1000);
    frames(499);
    chk("scroll_x1", pic_start_x, 1);
    chk("scroll_off0", scroll_offset, 0);
    frames(159);
    chk("scroll_off159", scroll_offset, 159);
    frames(1);
    chk("scroll_wrap_x", pic_start_x, 500);
    chk("scroll_wrap_off", scroll_offset, 0);
    frames(5);
    chk("scroll_x495", pic_start_x, 495);
    cyc(4'b0001, 1, 0);
    chk("exit_color", mode_out, 4'b0001);
    chk("exit_x", pic_start_x, 500);
    cyc(4'b1000, 1, 0);
    frames(3);
    cyc(4'b1000, 1, 0);
    chk("scroll_toggle", mode_out, 4'b0000);
    chk("scroll_toggle_x", pic_start_x, 500);
    chk("scroll_toggle_off", scroll_offset, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] kr;
      bit fe, cd;
      kr = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      if ($urandom_range(0, 1) == 0 && kr != 0) kr = 4'b0001 << $urandom_range(0, 3);
      fe = ($urandom_range(0, 7) == 0);
      cd = ($urandom_range(0, 40) == 0);
      cyc(kr, fe, cd);
      if (i == 2000) do_reset();
    end

    do_reset();
    cyc(4'b0000, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
